// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks (subtractor now, adder later).
package serial_arith_pkg;

  localparam int DEFAULT_WIDTH = 8;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE  = IDLE,
    S_SHIFT = SHIFT,
    S_DONE  = DONE
  } serial_state_e;

endpackage

// File: rtl/full_subtractor.sv
// One-bit combinational full subtractor: diff = a - b - bin, bout = borrow out.
module full_subtractor (
  output logic diff,
  output logic bout,
  input  logic a,
  input  logic b,
  input  logic bin
);

  assign diff = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first unsigned subtractor: one full-subtractor cell plus a borrow flop,
// producing (a - b - bin) mod 2^WIDTH and the borrow-out after WIDTH shift cycles.
module serial_subtractor
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  serial_state_e    state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             brw_q, brw_d;
  logic             bout_q, bout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             cell_diff;
  logic             cell_bout;
  logic [WIDTH-1:0] res_shift;

  full_subtractor u_cell (
    .diff (cell_diff),
    .bout (cell_bout),
    .a    (a_q[0]),
    .b    (b_q[0]),
    .bin  (brw_q)
  );

  // New bit enters at the MSB so the LSB-first stream lands in place after WIDTH shifts.
  generate
    if (WIDTH == 1) begin : g_res_w1
      assign res_shift = cell_diff;
    end else begin : g_res_wn
      assign res_shift = {cell_diff, res_q[WIDTH-1:1]};
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    diff_d  = diff_q;
    brw_d   = brw_q;
    bout_d  = bout_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          brw_d   = bin;
          cnt_d   = '0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        brw_d = cell_bout;
        res_d = res_shift;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_BIT) begin
          diff_d  = res_shift;
          bout_d  = cell_bout;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      diff_q  <= '0;
      brw_q   <= 1'b0;
      bout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      diff_q  <= diff_d;
      brw_q   <= brw_d;
      bout_q  <= bout_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_DONE);
  assign diff = diff_q;
  assign bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor at WIDTH=8 and WIDTH=1.
module tb_serial_subtractor;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       start8 = 1'b0, bin8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic [7:0] diff8;
  logic       busy8, done8, bout8;

  logic       start1 = 1'b0, bin1 = 1'b0;
  logic [0:0] a1 = '0, b1 = '0;
  logic [0:0] diff1;
  logic       busy1, done1, bout1;

  serial_subtractor #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .bin(bin8),
    .busy(busy8), .done(done8), .diff(diff8), .bout(bout8)
  );

  serial_subtractor #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .bin(bin1),
    .busy(busy1), .done(done1), .diff(diff1), .bout(bout1)
  );

  typedef struct packed {
    logic [7:0] diff;
    logic       bout;
  } exp_t;

  exp_t q8[$];
  exp_t q1[$];
  exp_t e8, e1;
  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] last_diff = 8'h00;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference arithmetic: 9-bit subtraction, sign bit is the borrow.
  function automatic logic [8:0] model8(input logic [7:0] a, input logic [7:0] b, input logic bi);
    return {1'b0, a} - {1'b0, b} - {8'd0, bi};
  endfunction

  function automatic logic [1:0] model1(input logic a, input logic b, input logic bi);
    return {1'b0, a} - {1'b0, b} - {1'b0, bi};
  endfunction

  always @(negedge clk) begin
    if (done8) begin
      if (q8.size() == 0) begin
        check("done8_unexpected", 32'd1, 32'd0);
      end else begin
        e8 = q8.pop_front();
        check("diff8", 32'(diff8), 32'(e8.diff));
        check("bout8", 32'(bout8), 32'(e8.bout));
        $display("[TB] w8 op done: diff=%02h bout=%0b (expected %02h/%0b)",
                 diff8, bout8, e8.diff, e8.bout);
      end
    end
    if (done1) begin
      if (q1.size() == 0) begin
        check("done1_unexpected", 32'd1, 32'd0);
      end else begin
        e1 = q1.pop_front();
        check("diff1", 32'(diff1), 32'(e1.diff));
        check("bout1", 32'(bout1), 32'(e1.bout));
        $display("[TB] w1 op done: diff=%0b bout=%0b (expected %0b/%0b)",
                 diff1, bout1, e1.diff[0], e1.bout);
      end
    end
  end

  // Called on a negedge; returns on the negedge of the first IDLE cycle after done.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic bi, input bit poke);
    logic [8:0] m;
    int busy_n;
    int done_at;
    m = model8(a, b, bi);
    start8 = 1'b1; a8 = a; b8 = b; bin8 = bi;
    q8.push_back('{diff: m[7:0], bout: m[8]});
    busy_n = 0;
    done_at = -1;
    @(posedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 0) begin
        start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
      end
      if (poke && i == 2) begin
        start8 = 1'b1; a8 = 8'hC3; b8 = 8'h3C; bin8 = 1'b1;
      end
      if (poke && i == 3) start8 = 1'b0;
      if (busy8) busy_n++;
      if (done8) begin
        if (done_at < 0) done_at = i;
        else check("done8_width", 32'(i), 32'(done_at));
      end
      if (i < 8) check("hold8", 32'(diff8), 32'(last_diff));
    end
    check("busy8_len", 32'(busy_n), 32'd9);
    check("done8_lat", 32'(done_at), 32'd8);
    last_diff = m[7:0];
  endtask

  task automatic do_op1(input logic a, input logic b, input logic bi);
    logic [1:0] m;
    int busy_n;
    int done_at;
    m = model1(a, b, bi);
    start1 = 1'b1; a1 = a; b1 = b; bin1 = bi;
    q1.push_back('{diff: {7'd0, m[0]}, bout: m[1]});
    busy_n = 0;
    done_at = -1;
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 0) begin
        start1 = 1'b0; a1 = 1'($urandom); b1 = 1'($urandom); bin1 = 1'($urandom);
      end
      if (busy1) busy_n++;
      if (done1 && done_at < 0) done_at = i;
    end
    check("busy1_len", 32'(busy_n), 32'd2);
    check("done1_lat", 32'(done_at), 32'd1);
  endtask

  task automatic idle_hold(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("idle_busy8", 32'(busy8), 32'd0);
      check("idle_done8", 32'(done8), 32'd0);
      check("idle_hold8", 32'(diff8), 32'(last_diff));
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset held with inputs toggling randomly.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      start8 = 1'($urandom); a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
      start1 = 1'($urandom); a1 = 1'($urandom); b1 = 1'($urandom); bin1 = 1'($urandom);
      check("rst_busy8", 32'(busy8), 32'd0);
      check("rst_done8", 32'(done8), 32'd0);
      check("rst_diff8", 32'(diff8), 32'h00);
      check("rst_bout8", 32'(bout8), 32'd0);
      check("rst_busy1", 32'(busy1), 32'd0);
    end
    @(negedge clk);
    start8 = 1'b0; start1 = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("post_rst_busy8", 32'(busy8), 32'd0);
      check("post_rst_done8", 32'(done8), 32'd0);
      check("post_rst_busy1", 32'(busy1), 32'd0);
    end

    do_op(8'h5A, 8'h23, 1'b0, 1'b0);
    do_op(8'h00, 8'h01, 1'b0, 1'b0);
    do_op(8'h80, 8'h7F, 1'b1, 1'b0);
    do_op(8'hFF, 8'hFF, 1'b1, 1'b0);
    idle_hold(3);
    // Ignored mid-op start, then a back-to-back op in the first IDLE cycle.
    do_op(8'h5A, 8'h23, 1'b0, 1'b1);
    do_op(8'h3C, 8'h3D, 1'b1, 1'b0);
    idle_hold(2);

    // Reset asserted in the middle of the shift phase.
    start8 = 1'b1; a8 = 8'h33; b8 = 8'h11; bin8 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy8", 32'(busy8), 32'd0);
    check("abort_done8", 32'(done8), 32'd0);
    check("abort_diff8", 32'(diff8), 32'h00);
    check("abort_bout8", 32'(bout8), 32'd0);
    $display("[TB] w8 op aborted by reset: busy=%0b diff=%02h", busy8, diff8);
    @(negedge clk);
    rst_n = 1'b1;
    last_diff = 8'h00;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("abort_no_done8", 32'(done8), 32'd0);
    end

    do_op(8'h10, 8'h01, 1'b0, 1'b0);
    idle_hold(1);

    do_op1(1'b0, 1'b1, 1'b0);
    do_op1(1'b1, 1'b0, 1'b1);
    do_op1(1'b1, 1'b1, 1'b1);
    do_op1(1'b1, 1'b0, 1'b0);

    repeat (2) @(negedge clk);
    check("sb8_empty", 32'(q8.size()), 32'd0);
    check("sb1_empty", 32'(q1.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
